nts_tx_arbiter: RTL and testbench
=================================

// Module: nts_tx_arbiter
// PURPOSE
//  Round-robin scheduler sharing the single extractor (MAC TX path) between ENGINES nts_engine TX FIFOs.
//  Sits between the engines' o_dispatch_tx_* ports and the extractor's i_engine_* ports in the top level.
//  Grants one engine per packet and muxes its FIFO to the extractor; a watchdog frees a stalled grant.
//  Exposes an enable mask and statistics on the dispatcher API bus.
// PARAMETERS
//  ENGINES          4     number of engines arbitrated (>=1)
//  MAC_DATA_WIDTH   64    TX FIFO word width
//  API_ADDR_WIDTH   12    API address width
//  API_RW_WIDTH     32    API data width
//  TIMEOUT_CYCLES   1024  idle cycles in GRANT before forced release (>=2)
//  HOLDOFF_CYCLES   2     cycles in HOLDOFF after release (>=1)
// PORTS
//  i_clk                      in   1                 clock
//  i_areset                   in   1                 reset, synchronous, active-high
//  i_engine_packet_available  in   ENGINES           per-engine TX packet ready
//  o_engine_packet_read       out  ENGINES           per-engine packet-read pulse
//  i_engine_fifo_empty        in   ENGINES           per-engine FIFO empty
//  o_engine_fifo_rd_en        out  ENGINES           per-engine FIFO read enable
//  i_engine_fifo_rd_data      in   ENGINES*MAC_DATA_WIDTH  packed per-engine FIFO data
//  i_engine_bytes_last_word   in   ENGINES*4         packed per-engine last-word byte count
//  o_extractor_packet_available out 1                granted engine's packet_available
//  i_extractor_packet_read    in   1                 extractor finished packet
//  o_extractor_fifo_empty     out  1                 granted engine's fifo_empty (1 when no grant)
//  i_extractor_fifo_rd_en     in   1                 extractor FIFO read
//  o_extractor_fifo_rd_data   out  MAC_DATA_WIDTH    granted engine's data (0 when no grant)
//  o_extractor_bytes_last_word out 4                 granted engine's byte count (0 when no grant)
//  i_api_cs/i_api_we          in   1/1               API select / write
//  i_api_address              in   API_ADDR_WIDTH    API address
//  i_api_write_data           in   API_RW_WIDTH      API write data
//  o_api_read_data            out  API_RW_WIDTH      registered read data; 0 when not addressed (OR-combined)
// BEHAVIOUR
//  Reset: state IDLE, grant 0, rr_ptr 0, enable mask all ones, counters 0; all outputs 0 except o_extractor_fifo_empty=1.
//  FSM IDLE->GRANT->HOLDOFF->IDLE.
//  IDLE: req = i_engine_packet_available & mask; if req!=0, grant <= first set bit at or after rr_ptr (wrapping); ->GRANT.
//   Request seen in cycle N -> o_extractor_packet_available high in N+1.
//  GRANT: extractor outputs = granted engine's inputs (mux on registered grant, combinational data path).
//   o_engine_fifo_rd_en[grant]=i_extractor_fifo_rd_en; all other bits 0.
//   o_engine_packet_read[grant]=i_extractor_packet_read, same cycle; ->HOLDOFF; rr_ptr <= (grant+1) mod ENGINES.
//   Watchdog: cleared on rd_en or packet_read, else +1; on reaching TIMEOUT_CYCLES -> HOLDOFF, timeout_cnt+1, rr_ptr advances, no packet_read issued.
//   Granted engine's available drops without packet_read (engine reset) -> HOLDOFF, drop_cnt+1.
//   packet_read and timeout in same cycle: packet_read wins, no timeout counted.
//  HOLDOFF: extractor sees available=0, empty=1, no rd_en forwarded; stay HOLDOFF_CYCLES then IDLE.
//   Lets the engine's available deassert.
//  Mask writes take effect at the next IDLE decision; the current grant is never revoked by mask.
//  ENGINES=1: rr_ptr constant 0; behaviour otherwise identical.
//  Counters 32-bit, saturate at 0xFFFFFFFF; API write to a counter clears it.
//  API regs (word address):
//   0x00 CTRL      RW  mask[ENGINES-1:0]
//   0x01 STATUS    RO  {state[1:0] @[17:16], grant @[7:0]}
//   0x02 TIMEOUTS  RW-clear
//   0x03 DROPS     RW-clear
//  API read latency: 1 cycle. API write to an unused address: ignored. Reset mid-GRANT: immediate return to reset state.
// CONFIGURATION
//  NTS_TX_ARBITER_GRANT_COUNTERS_EN defined:
//   per-engine 32-bit grant counters at 0x10+e; +1 on each GRANT entry; saturating; write clears.
//  Not defined: counters absent; 0x10+e read 0; no counter logic synthesized.
// STRUCTURE
//  nts_tx_arbiter_pkg.vh:
//   state encodings (IDLE=0, GRANT=1, HOLDOFF=2)
//   API address constants
//   LAST_DATA_VALID_WIDTH=4
//  Sub-module nts_rr_picker: combinational (req, mask, ptr) -> (valid, index).
// TESTING
//  ENGINES=4, mask=0xF, engines 1 and 3 available at once, rr_ptr=0 -> grant 1; after its packet_read and HOLDOFF, grant 3.
//  Granted engine 2: extractor rd_en x5 -> only o_engine_fifo_rd_en[2] pulses 5 times; rd_data/bytes_last_word match engine 2.
//  TIMEOUT_CYCLES=16, grant with no rd_en -> release at cycle 16; TIMEOUTS reads 1; o_engine_packet_read stays 0.
//  Write CTRL=0x5 during grant to engine 1 -> engine 1 completes; later requests from 1/3 ignored, 0/2 served.
//  Reset pulse mid-GRANT -> next cycle extractor sees available=0, empty=1; STATUS=0; CTRL reads 0xF.
//  With NTS_TX_ARBITER_GRANT_COUNTERS_EN, 3 packets from engine 0 -> 0x10 reads 3; write clears to 0; without the macro, 0x10 reads 0.

Source files
------------

// File: rtl/nts_tx_arbiter_pkg.sv
// Shared types and constants for the NTS TX arbiter: FSM encoding, API register map,
// byte-count width and a saturating-increment helper for the statistics counters.
package nts_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HOLDOFF = 2'd2
    } arb_state_t;

    localparam int LAST_DATA_VALID_WIDTH = 4;
    localparam int CNT_WIDTH             = 32;

    localparam int ADDR_CTRL           = 'h00;
    localparam int ADDR_STATUS         = 'h01;
    localparam int ADDR_TIMEOUTS       = 'h02;
    localparam int ADDR_DROPS          = 'h03;
    localparam int ADDR_GRANT_CNT_BASE = 'h10;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (value == '1) ? value : value + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/nts_rr_picker.sv
// Combinational round-robin pick: first requesting, enabled engine at or after ptr, wrapping.
module nts_rr_picker #(
    parameter int ENGINES = 4,
    parameter int IDX_W   = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
    input  logic [ENGINES-1:0] req,
    input  logic [ENGINES-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    logic [ENGINES-1:0] eligible;
    int                 cand;

    assign eligible = req & mask;

    // NOTE: every output of a combinational block gets a default before any branch,
    // otherwise synthesis infers a latch to hold the unassigned value.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        // Walk from the farthest offset down so the nearest eligible engine is written last.
        for (int i = ENGINES - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= ENGINES) cand = cand - ENGINES;
            if (eligible[cand]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/nts_tx_arbiter.sv
// Round-robin arbiter sharing the extractor TX path between engine TX FIFOs, with watchdog and API stats.
// Optional per-engine grant counters: define NTS_TX_ARBITER_GRANT_COUNTERS_EN.
module nts_tx_arbiter
    import nts_tx_arbiter_pkg::*;
#(
    parameter int ENGINES        = 4,
    parameter int MAC_DATA_WIDTH = 64,
    parameter int API_ADDR_WIDTH = 12,
    parameter int API_RW_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int HOLDOFF_CYCLES = 2
) (
    input  logic                                       i_clk,
    input  logic                                       i_areset,
    input  logic [ENGINES-1:0]                         i_engine_packet_available,
    output logic [ENGINES-1:0]                         o_engine_packet_read,
    input  logic [ENGINES-1:0]                         i_engine_fifo_empty,
    output logic [ENGINES-1:0]                         o_engine_fifo_rd_en,
    input  logic [ENGINES*MAC_DATA_WIDTH-1:0]          i_engine_fifo_rd_data,
    input  logic [ENGINES*LAST_DATA_VALID_WIDTH-1:0]   i_engine_bytes_last_word,
    output logic                                       o_extractor_packet_available,
    input  logic                                       i_extractor_packet_read,
    output logic                                       o_extractor_fifo_empty,
    input  logic                                       i_extractor_fifo_rd_en,
    output logic [MAC_DATA_WIDTH-1:0]                  o_extractor_fifo_rd_data,
    output logic [LAST_DATA_VALID_WIDTH-1:0]           o_extractor_bytes_last_word,
    input  logic                                       i_api_cs,
    input  logic                                       i_api_we,
    input  logic [API_ADDR_WIDTH-1:0]                  i_api_address,
    input  logic [API_RW_WIDTH-1:0]                    i_api_write_data,
    output logic [API_RW_WIDTH-1:0]                    o_api_read_data
);

    localparam int IDX_W = (ENGINES > 1) ? $clog2(ENGINES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    arb_state_t             state;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       next_ptr;
    logic [ENGINES-1:0]     mask;
    logic [WD_W-1:0]        wd_cnt;
    logic [HO_W-1:0]        ho_cnt;
    logic [CNT_WIDTH-1:0]   timeout_cnt;
    logic [CNT_WIDTH-1:0]   drop_cnt;
    logic [API_RW_WIDTH-1:0] read_mux;

    logic pick_valid;
    logic [IDX_W-1:0] pick_index;
    logic granted, grant_avail, grant_start;
    logic ev_done, ev_drop, ev_timeout, release_grant;
    logic api_wr, api_rd;
    logic unused_write_bits;

    nts_rr_picker #(
        .ENGINES (ENGINES),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (i_engine_packet_available),
        .mask  (mask),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .index (pick_index)
    );

    assign granted     = (state == ST_GRANT);
    assign grant_avail = i_engine_packet_available[grant];
    assign grant_start = (state == ST_IDLE) && pick_valid;
    assign next_ptr    = (grant == IDX_W'(ENGINES - 1)) ? '0 : grant + IDX_W'(1);

    // Release priority: completed packet, then vanished request, then watchdog expiry.
    assign ev_done       = granted && i_extractor_packet_read;
    assign ev_drop       = granted && !i_extractor_packet_read && !grant_avail;
    assign ev_timeout    = granted && !i_extractor_packet_read && grant_avail &&
                           !i_extractor_fifo_rd_en && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign release_grant = ev_done || ev_drop || ev_timeout;

    assign api_wr            = i_api_cs && i_api_we;
    assign api_rd            = i_api_cs && !i_api_we;
    assign unused_write_bits = ^i_api_write_data;

    always_comb begin
        o_extractor_packet_available = 1'b0;
        o_extractor_fifo_empty       = 1'b1;
        o_extractor_fifo_rd_data     = '0;
        o_extractor_bytes_last_word  = '0;
        o_engine_fifo_rd_en          = '0;
        o_engine_packet_read         = '0;
        if (granted) begin
            o_extractor_packet_available = grant_avail;
            o_extractor_fifo_empty       = i_engine_fifo_empty[grant];
            o_extractor_fifo_rd_data     = i_engine_fifo_rd_data[grant*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
            o_extractor_bytes_last_word  =
                i_engine_bytes_last_word[grant*LAST_DATA_VALID_WIDTH +: LAST_DATA_VALID_WIDTH];
            o_engine_fifo_rd_en[grant]   = i_extractor_fifo_rd_en;
            o_engine_packet_read[grant]  = i_extractor_packet_read;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order or block scheduling.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state  <= ST_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            wd_cnt <= '0;
            ho_cnt <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state  <= ST_GRANT;
                        grant  <= pick_index;
                        wd_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_grant) begin
                        state  <= ST_HOLDOFF;
                        ho_cnt <= '0;
                        rr_ptr <= next_ptr;
                    end else if (i_extractor_fifo_rd_en) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (ho_cnt == HO_W'(HOLDOFF_CYCLES - 1)) state <= ST_IDLE;
                    else                                      ho_cnt <= ho_cnt + HO_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A write to a counter clears it and takes precedence over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            mask        <= '1;
            timeout_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (api_wr && i_api_address == API_ADDR_WIDTH'(ADDR_CTRL))
                mask <= i_api_write_data[ENGINES-1:0];
            if (api_wr && i_api_address == API_ADDR_WIDTH'(ADDR_TIMEOUTS)) timeout_cnt <= '0;
            else if (ev_timeout)                                           timeout_cnt <= sat_inc(timeout_cnt);
            if (api_wr && i_api_address == API_ADDR_WIDTH'(ADDR_DROPS)) drop_cnt <= '0;
            else if (ev_drop)                                           drop_cnt <= sat_inc(drop_cnt);
        end
    end

`ifdef NTS_TX_ARBITER_GRANT_COUNTERS_EN
    logic [CNT_WIDTH-1:0] grant_cnt [ENGINES];

    // NOTE: these counters are a few flops, not a RAM, so they reset like any register.
    always_ff @(posedge i_clk) begin
        for (int e = 0; e < ENGINES; e++) begin
            if (i_areset)
                grant_cnt[e] <= '0;
            else if (api_wr && i_api_address == API_ADDR_WIDTH'(ADDR_GRANT_CNT_BASE + e))
                grant_cnt[e] <= '0;
            else if (grant_start && pick_index == IDX_W'(e))
                grant_cnt[e] <= sat_inc(grant_cnt[e]);
        end
    end
`endif

    always_comb begin
        read_mux = '0;
        if (i_api_address == API_ADDR_WIDTH'(ADDR_CTRL)) begin
            read_mux[ENGINES-1:0] = mask;
        end else if (i_api_address == API_ADDR_WIDTH'(ADDR_STATUS)) begin
            read_mux[17:16] = state;
            read_mux[7:0]   = 8'(grant);
        end else if (i_api_address == API_ADDR_WIDTH'(ADDR_TIMEOUTS)) begin
            read_mux = API_RW_WIDTH'(timeout_cnt);
        end else if (i_api_address == API_ADDR_WIDTH'(ADDR_DROPS)) begin
            read_mux = API_RW_WIDTH'(drop_cnt);
        end
`ifdef NTS_TX_ARBITER_GRANT_COUNTERS_EN
        for (int e = 0; e < ENGINES; e++) begin
            if (i_api_address == API_ADDR_WIDTH'(ADDR_GRANT_CNT_BASE + e))
                read_mux = API_RW_WIDTH'(grant_cnt[e]);
        end
`endif
    end

    // Read data is zero whenever this block is not being read, so it can be OR-combined.
    always_ff @(posedge i_clk) begin
        if (i_areset) o_api_read_data <= '0;
        else          o_api_read_data <= api_rd ? read_mux : '0;
    end

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// Self-checking bench for nts_tx_arbiter: directed scenarios then randomized traffic,
// all cycles compared against a transaction-level reference model.
module tb_nts_tx_arbiter;

    localparam int E  = 4;
    localparam int W  = 64;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int T  = 16;
    localparam int H  = 2;
`ifdef NTS_TX_ARBITER_GRANT_COUNTERS_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic            i_areset;
    logic [E-1:0]    avail, empty;
    logic [E*W-1:0]  fdata;
    logic [E*4-1:0]  fbytes;
    logic            ext_pr, ext_rd, api_cs, api_we;
    logic [AW-1:0]   api_addr;
    logic [DW-1:0]   api_wdata;
    logic [E-1:0]    pkt_read, rd_en;
    logic            x_avail, x_empty;
    logic [W-1:0]    x_data;
    logic [3:0]      x_bytes;
    logic [DW-1:0]   api_rdata;

    nts_tx_arbiter #(
        .ENGINES(E), .MAC_DATA_WIDTH(W), .API_ADDR_WIDTH(AW), .API_RW_WIDTH(DW),
        .TIMEOUT_CYCLES(T), .HOLDOFF_CYCLES(H)
    ) dut (
        .i_clk                        (i_clk),
        .i_areset                     (i_areset),
        .i_engine_packet_available    (avail),
        .o_engine_packet_read         (pkt_read),
        .i_engine_fifo_empty          (empty),
        .o_engine_fifo_rd_en          (rd_en),
        .i_engine_fifo_rd_data        (fdata),
        .i_engine_bytes_last_word     (fbytes),
        .o_extractor_packet_available (x_avail),
        .i_extractor_packet_read      (ext_pr),
        .o_extractor_fifo_empty       (x_empty),
        .i_extractor_fifo_rd_en       (ext_rd),
        .o_extractor_fifo_rd_data     (x_data),
        .o_extractor_bytes_last_word  (x_bytes),
        .i_api_cs                     (api_cs),
        .i_api_we                     (api_we),
        .i_api_address                (api_addr),
        .i_api_write_data             (api_wdata),
        .o_api_read_data              (api_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner = engine holding the extractor (-1 none), hold = quiet cycles left.
    bit          m_valid = 1'b0;
    int          m_owner, m_hold, m_wd, m_ptr, m_last;
    logic [E-1:0] m_mask;
    logic [31:0] m_to, m_dr, m_rdata;
    logic [31:0] m_gc [E];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic void m_reset();
        m_valid = 1'b1;
        m_owner = -1; m_hold = 0; m_wd = 0; m_ptr = 0; m_last = 0;
        m_mask = '1; m_to = 0; m_dr = 0; m_rdata = 0;
        for (int e = 0; e < E; e++) m_gc[e] = 0;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        int phase;
        phase = (m_owner >= 0) ? 1 : (m_hold > 0) ? 2 : 0;
        if (a == 0) return 32'(m_mask);
        if (a == 1) return 32'((phase << 16) | m_last);
        if (a == 2) return m_to;
        if (a == 3) return m_dr;
        if (GC_EN && a >= 16 && a < 16 + E) return m_gc[a-16];
        return 32'h0;
    endfunction

    function automatic void m_release();
        m_ptr   = (m_owner + 1) % E;
        m_owner = -1;
        m_hold  = H;
        m_wd    = 0;
    endfunction

    function automatic void m_step();
        logic [31:0] rd_next;
        int a;
        if (i_areset) begin
            m_reset();
            return;
        end
        a = int'(api_addr);
        rd_next = (api_cs && !api_we) ? m_read(a) : 32'h0;
        if (m_owner >= 0) begin
            if (ext_pr) m_release();
            else if (!avail[m_owner]) begin m_dr = sat(m_dr); m_release(); end
            else if (ext_rd) m_wd = 0;
            else begin
                m_wd++;
                if (m_wd == T) begin m_to = sat(m_to); m_release(); end
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            for (int i = 0; i < E; i++) begin
                int e = (m_ptr + i) % E;
                if (m_owner < 0 && avail[e] && m_mask[e]) begin
                    m_owner = e; m_last = e; m_wd = 0; m_gc[e] = sat(m_gc[e]);
                end
            end
        end
        if (api_cs && api_we) begin
            if (a == 0) m_mask = api_wdata[E-1:0];
            else if (a == 2) m_to = 0;
            else if (a == 3) m_dr = 0;
            else if (a >= 16 && a < 16 + E) m_gc[a-16] = 0;
        end
        m_rdata = rd_next;
    endfunction

    // One clock: compare every output with the model, advance the model, cross the edge.
    task automatic cycle();
        logic         e_av, e_em;
        logic [W-1:0] e_d;
        logic [3:0]   e_b;
        logic [E-1:0] e_rd, e_pr;
        #1;
        if (m_valid) begin
            e_av = 1'b0; e_em = 1'b1; e_d = '0; e_b = '0; e_rd = '0; e_pr = '0;
            if (m_owner >= 0) begin
                e_av = avail[m_owner];
                e_em = empty[m_owner];
                e_d  = fdata[m_owner*W +: W];
                e_b  = fbytes[m_owner*4 +: 4];
                e_rd = ext_rd ? (E'(1) << m_owner) : '0;
                e_pr = ext_pr ? (E'(1) << m_owner) : '0;
            end
            check("x_avail", 64'(x_avail), 64'(e_av));
            check("x_empty", 64'(x_empty), 64'(e_em));
            check("x_data", x_data, e_d);
            check("x_bytes", 64'(x_bytes), 64'(e_b));
            check("eng_rd_en", 64'(rd_en), 64'(e_rd));
            check("eng_pkt_read", 64'(pkt_read), 64'(e_pr));
            check("api_rdata", 64'(api_rdata), 64'(m_rdata));
        end
        m_step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic api_read(input int a, output logic [31:0] v);
        api_cs = 1'b1; api_we = 1'b0; api_addr = AW'(a);
        cycle();
        api_cs = 1'b0;
        v = api_rdata;
    endtask

    task automatic api_write(input int a, input logic [31:0] d);
        api_cs = 1'b1; api_we = 1'b1; api_addr = AW'(a); api_wdata = d;
        cycle();
        api_cs = 1'b0; api_we = 1'b0;
    endtask

    task automatic rand_data();
        for (int e = 0; e < E; e++) begin
            fdata[e*W +: W] = {$urandom, $urandom};
            fbytes[e*4 +: 4] = 4'($urandom_range(15));
        end
    endtask

    task automatic rand_inputs(input int rd_pct, input int pr_pct);
        int r;
        for (int e = 0; e < E; e++) begin
            if (avail[e]) begin if ($urandom_range(99) < 3) avail[e] = 1'b0; end
            else if ($urandom_range(99) < 15) avail[e] = 1'b1;
            empty[e] = ($urandom_range(99) < 20);
        end
        rand_data();
        ext_rd   = ($urandom_range(99) < rd_pct);
        ext_pr   = ($urandom_range(99) < pr_pct);
        i_areset = ($urandom_range(999) < 2);
        r = $urandom_range(99);
        api_cs = 1'b0; api_we = 1'b0;
        if (r < 13) begin
            case ($urandom_range(5))
                0: api_addr = AW'(0);
                1: api_addr = AW'(1);
                2: api_addr = AW'(2);
                3: api_addr = AW'(3);
                4: api_addr = AW'(16 + $urandom_range(E - 1));
                default: api_addr = AW'(7);
            endcase
            api_cs = 1'b1;
            api_we = (r >= 10);
            api_wdata = (api_addr == AW'(0)) ? 32'($urandom_range(1, 15)) : $urandom;
        end
    endtask

    logic [31:0] v;
    logic [E-1:0] other;
    int pulses;
    logic pr_seen;

    initial begin
        i_areset = 1'b1; avail = '0; empty = '0; fdata = '0; fbytes = '0;
        ext_pr = 1'b0; ext_rd = 1'b0; api_cs = 1'b0; api_we = 1'b0; api_addr = '0; api_wdata = '0;
        rand_data();
        idle(2);
        i_areset = 1'b0;
        check("rst_x_empty", 64'(x_empty), 64'd1);
        check("rst_x_avail", 64'(x_avail), 64'd0);
        api_read(1, v); check("rst_status", 64'(v), 64'h0);
        api_read(0, v); check("rst_ctrl", 64'(v), 64'hF);

        // Engines 1 and 3 request together with rr_ptr=0: 1 first, then 3.
        avail = 4'b1010;
        cycle();
        check("a_latency", 64'(x_avail), 64'd1);
        check("a_data", x_data, fdata[1*W +: W]);
        api_read(1, v); check("a_status_g1", 64'(v), 64'h10001);
        ext_pr = 1'b1; #1;
        check("a_pkt_read", 64'(pkt_read), 64'b0010);
        cycle();
        ext_pr = 1'b0; avail = 4'b1000;
        idle(3);
        api_read(1, v); check("a_status_g3", 64'(v), 64'h10003);
        ext_pr = 1'b1; cycle(); ext_pr = 1'b0; avail = '0;

        // Engine 2 granted, five extractor reads forwarded only to engine 2.
        idle(2);
        avail = 4'b0100;
        cycle();
        pulses = 0; other = '0;
        for (int i = 0; i < 5; i++) begin
            ext_rd = 1'b1; rand_data(); #1;
            pulses += int'(rd_en[2]);
            other  |= rd_en & 4'b1011;
            check("b_data", x_data, fdata[2*W +: W]);
            check("b_bytes", 64'(x_bytes), 64'(fbytes[2*4 +: 4]));
            cycle();
        end
        ext_rd = 1'b0;
        check("b_rd_pulses", 64'(pulses), 64'd5);
        check("b_other_rd", 64'(other), 64'd0);
        ext_pr = 1'b1; cycle(); ext_pr = 1'b0; avail = '0;

        // Watchdog: no activity for T grant cycles forces a release without packet_read.
        idle(2);
        avail = 4'b0001;
        cycle();
        pr_seen = 1'b0;
        for (int i = 0; i < T - 1; i++) begin
            #1; pr_seen |= |pkt_read;
            cycle();
        end
        check("c_still_granted", 64'(x_avail), 64'd1);
        #1; pr_seen |= |pkt_read;
        cycle();
        check("c_released", 64'(x_avail), 64'd0);
        api_read(2, v); check("c_timeouts", 64'(v), 64'd1);
        check("c_no_pkt_read", 64'(pr_seen), 64'd0);
        avail = '0;

        // Mask change during a grant: current grant completes, masked engines then ignored.
        idle(2);
        avail = 4'b0010;
        cycle();
        api_write(0, 32'h5);
        check("d_not_revoked", 64'(x_avail), 64'd1);
        ext_pr = 1'b1; cycle(); ext_pr = 1'b0; avail = 4'b1111;
        idle(3);
        api_read(1, v); check("d_grant2", 64'(v), 64'h10002);
        ext_pr = 1'b1; cycle(); ext_pr = 1'b0;
        idle(3);
        api_read(1, v); check("d_grant0", 64'(v), 64'h10000);
        ext_pr = 1'b1; cycle(); ext_pr = 1'b0; avail = '0;
        api_write(0, 32'hF);

        // Reset pulse while a grant is active.
        cycle();
        avail = 4'b0100;
        cycle();
        i_areset = 1'b1; cycle(); i_areset = 1'b0;
        check("e_avail", 64'(x_avail), 64'd0);
        check("e_empty", 64'(x_empty), 64'd1);
        api_read(1, v); check("e_status", 64'(v), 64'h0);
        api_read(0, v); check("e_ctrl", 64'(v), 64'hF);
        ext_pr = 1'b1; cycle(); ext_pr = 1'b0; avail = '0;

        // Granted engine withdraws its request: counted as a drop.
        idle(2);
        avail = 4'b0001;
        cycle();
        avail = '0;
        cycle();
        api_read(3, v); check("drop_cnt", 64'(v), 64'd1);

        // Grant counters (read 0 when the feature is built out).
        api_write(16, 32'h0);
        for (int p = 0; p < 3; p++) begin
            idle(2);
            avail = 4'b0001; cycle();
            ext_pr = 1'b1; cycle(); ext_pr = 1'b0; avail = '0;
        end
        api_read(16, v); check("gc_e0", 64'(v), GC_EN ? 64'd3 : 64'd0);
        api_write(16, 32'h0);
        api_read(16, v); check("gc_clear", 64'(v), 64'd0);

        // Randomized traffic under three extractor behaviours.
        for (int prof = 0; prof < 3; prof++) begin
            for (int c = 0; c < 1000; c++) begin
                case (prof)
                    0: rand_inputs(50, 8);
                    1: rand_inputs(0, 0);
                    default: rand_inputs(20, 3);
                endcase
                cycle();
            end
        end
        i_areset = 1'b0; ext_rd = 1'b0; ext_pr = 1'b0; api_cs = 1'b0; api_we = 1'b0;
        for (int a = 0; a < 4; a++) api_read(a, v);
        for (int e = 0; e < E; e++) api_read(16 + e, v);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
